// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer, 16x oversampled, 8 data bits, optional parity, 1 stop bit
module uart_rx_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick16,
  input  logic       rx_in,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state;
  logic       rx_meta;
  logic       rx_s;
  logic       armed;
  logic       par_en_l;
  logic       par_odd_l;
  logic       perr;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      perr       <= 1'b0;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (tick16) begin
        case (state)
          IDLE: begin
            if (armed && !rx_s) begin
              state     <= START;
              tick_cnt  <= 4'd0;
              armed     <= 1'b0;
              busy      <= 1'b1;
              par_en_l  <= parity_en;
              par_odd_l <= parity_odd;
              perr      <= 1'b0;
            end else if (rx_s) begin
              armed <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == 4'd7) begin
              // A high line at mid start bit is a glitch, not a frame.
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state    <= DATA;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          DATA: begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shift[bit_cnt] <= rx_s;
              if (bit_cnt == 3'd7) begin
                state <= par_en_l ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          PARITY: begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              perr  <= (^shift) ^ rx_s ^ par_odd_l;
              state <= STOP;
            end
          end
          STOP: begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              data_out   <= shift;
              frame_err  <= ~rx_s;
              parity_err <= par_en_l & perr;
              data_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick16 = 1'b0;
  logic       rx_in = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick16    (tick16),
    .rx_in     (rx_in),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One tick16 every 4 clk, changed on the falling edge.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      phase  = (phase + 1) % 4;
      tick16 = (phase == 0);
    end
  end

  // Capture every valid strobe together with busy now and one clk earlier.
  logic [7:0] rec_d [64];
  bit         rec_pe[64];
  bit         rec_fe[64];
  bit         rec_b [64];
  bit         rec_pb[64];
  int         vld_cnt = 0;
  bit         prev_busy = 1'b0;

  always @(negedge clk) begin
    if (data_valid && vld_cnt < 64) begin
      rec_d[vld_cnt]  = data_out;
      rec_pe[vld_cnt] = parity_err;
      rec_fe[vld_cnt] = frame_err;
      rec_b[vld_cnt]  = busy;
      rec_pb[vld_cnt] = prev_busy;
      vld_cnt         = vld_cnt + 1;
    end
    prev_busy = busy;
  end

  int checks = 0;
  int errors = 0;
  int rd     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick16) @(posedge clk);
    end
    #1;
  endtask

  // Behavioural parity model: total ones over data+parity must be even (even) or odd (odd).
  function automatic bit model_perr(input logic [7:0] d, input bit pen, input bit podd, input bit pbit);
    int ones;
    if (!pen) return 1'b0;
    ones = $countones(d) + int'(pbit);
    return ((ones % 2) == 1) != podd;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                            input bit pbit, input bit stop);
    parity_en  = pen;
    parity_odd = podd;
    rx_in      = 1'b1;
    wait_ticks(3);
    rx_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      wait_ticks(16);
    end
    if (pen) begin
      rx_in = pbit;
      wait_ticks(16);
    end
    rx_in = stop;
    wait_ticks(16);
    rx_in = 1'b1;
    wait_ticks(4);
  endtask

  task automatic expect_frames(input string name, input int n, input logic [7:0] d,
                               input bit pe, input bit fe);
    chk({name, "_count"}, vld_cnt - rd, n);
    while (rd < vld_cnt) begin
      chk({name, "_data"}, rec_d[rd], d);
      chk({name, "_perr"}, rec_pe[rd], pe);
      chk({name, "_ferr"}, rec_fe[rd], fe);
      chk({name, "_busy_at_valid"}, rec_b[rd], 0);
      chk({name, "_busy_before_valid"}, rec_pb[rd], 1);
      rd++;
    end
    chk({name, "_busy_after"}, busy, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         pen;
    bit         podd;
    bit         pbit;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;

    // Directed frames with hand-derived expectations.
    vecs.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0});
    vecs.push_back('{8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 8'h37, 1'b1, 1'b0});
    vecs.push_back('{8'h37, 1'b1, 1'b1, 1'b0, 1'b1, 8'h37, 1'b0, 1'b0});
    vecs.push_back('{8'h37, 1'b1, 1'b1, 1'b1, 1'b1, 8'h37, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    for (int i = 0; i < 14; i++) begin
      v.data     = 8'($urandom);
      v.pen      = 1'($urandom);
      v.podd     = 1'($urandom);
      v.pbit     = 1'($urandom);
      v.stop     = ($urandom_range(0, 3) != 0);
      v.exp_data = v.data;
      v.exp_perr = model_perr(v.data, v.pen, v.podd, v.pbit);
      v.exp_ferr = !v.stop;
      vecs.push_back(v);
    end

    // Reset with the line low.
    rst   = 1'b1;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    wait_ticks(1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    wait_ticks(10);
    chk("rst_low_line_busy", busy, 0);
    chk("rst_low_line_valid", vld_cnt, 0);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].podd, vecs[i].pbit, vecs[i].stop);
      expect_frames($sformatf("vec%0d", i), 1, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
    end

    // Glitch: low for 5 ticks then high.
    parity_en = 1'b0;
    rx_in     = 1'b1;
    wait_ticks(3);
    rx_in = 1'b0;
    wait_ticks(2);
    chk("glitch_busy_during", busy, 1);
    wait_ticks(3);
    rx_in = 1'b1;
    wait_ticks(16);
    expect_frames("glitch", 0, 8'h00, 1'b0, 1'b0);

    // Break: line low for 20 bit times.
    rx_in = 1'b1;
    wait_ticks(3);
    rx_in = 1'b0;
    wait_ticks(320);
    expect_frames("break", 1, 8'h00, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_frames("after_break", 1, 8'h5A, 1'b0, 1'b0);

    // Reset during data bit 4.
    rx_in = 1'b1;
    wait_ticks(3);
    rx_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b1;
      wait_ticks(16);
    end
    wait_ticks(8);
    chk("midrst_busy_before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_parity_err", parity_err, 0);
    chk("midrst_frame_err", frame_err, 0);
    wait_ticks(200);
    expect_frames("midrst", 0, 8'h00, 1'b0, 1'b0);
    chk("midrst_data_held", data_out, 8'h00);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_frames("after_midrst", 1, 8'hC3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
